// File: rtl/alu_cmd_issuer.sv
// Command sequencer in front of the 8-operation ALU: buffers commands in a FIFO,
// issues them one at a time on registered operands and returns captured results.
module alu_cmd_issuer #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_opcode,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [DW-1:0] cmd_c,
  input  logic [DW-1:0] cmd_d,
  input  logic          cmd_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] alu_c,
  output logic [DW-1:0] alu_d,
  output logic [2:0]    alu_opcode,
  output logic          alu_sel,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_zero,
  output logic [2:0]    rsp_opcode,
  output logic          busy,
  input  logic          stat_clr,
  output logic [15:0]   stat_issued,
  output logic [15:0]   stat_zero
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 4 * DW + 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head_p0;
  logic          push, pop, capture, empty, full;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head_p0   = fifo_mem[rd_ptr];
  assign busy      = !empty || (state != IDLE);

  // FIFO storage holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_opcode, cmd_sel, cmd_a, cmd_b, cmd_c, cmd_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Issue stage: operands change only on a pop edge and stay put through EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      {alu_opcode, alu_sel, alu_a, alu_b, alu_c, alu_d} <= '0;
    end else if (pop) begin
      {alu_opcode, alu_sel, alu_a, alu_b, alu_c, alu_d} <= head_p0;
    end
  end

  // Response stage: capture at the end of EXEC, hold until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_opcode <= '0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_opcode <= alu_opcode;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_issued <= '0;
      stat_zero   <= '0;
    end else begin
      if (pop)                 stat_issued <= sat_inc(stat_issued);
      if (capture && alu_zero) stat_zero   <= sat_inc(stat_zero);
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural 8-operation ALU attached.
module tb_alu_cmd_issuer;
  localparam int DW = 8;
  localparam int FIFO_DEPTH = 4;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_SEL_SUM = 3'd6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_opcode = '0;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0, cmd_c = '0, cmd_d = '0;
  logic          cmd_sel = 1'b0;
  logic [DW-1:0] alu_a, alu_b, alu_c, alu_d;
  logic [2:0]    alu_opcode;
  logic          alu_sel;
  logic [DW-1:0] alu_result, rev_sum;
  logic          alu_zero;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic [2:0]    rsp_opcode;
  logic          busy;
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_issued, stat_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;

  typedef struct {
    logic [DW-1:0] result;
    logic          zero;
    logic [2:0]    op;
    int            cyc;
  } rsp_t;
  rsp_t q[$];

  alu_cmd_issuer #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
    .alu_opcode(alu_opcode), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_opcode(rsp_opcode), .busy(busy),
    .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_zero(stat_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU: ADD sums all four, SEL_SUM picks a+c or b+d, ADDReverse bit-reverses a+b
  always_comb begin
    rev_sum    = alu_a + alu_b;
    alu_result = '0;
    case (alu_opcode)
      3'd0:    alu_result = alu_a + alu_b + alu_c + alu_d;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = ~alu_a;
      3'd6:    alu_result = alu_sel ? (alu_a + alu_c) : (alu_b + alu_d);
      default: for (int i = 0; i < DW; i++) alu_result[i] = rev_sum[DW-1-i];
    endcase
  end
  assign alu_zero = (alu_result == '0);

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready)
      q.push_back('{result: rsp_result, zero: rsp_zero, op: rsp_opcode, cyc: cyc});
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d, input logic sel);
    bit ok = 0;
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d; cmd_sel = sel;
    cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    last_hs = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin errors++; checks++; $display("FAIL cmd_accept_timeout got ready=0 exp ready=1"); end
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q.size() >= n) break;
      @(negedge clk); #1;
    end
    checks++;
    if (q.size() < n) begin errors++; $display("FAIL rsp_timeout got %0d exp %0d", q.size(), n); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({alu_a, alu_b, alu_c, alu_d, alu_opcode, alu_sel} !== '0) begin errors++; $display("FAIL reset_alu got %h exp 0", {alu_a, alu_b, alu_c, alu_d}); end
    checks++; if ({rsp_result, rsp_zero, rsp_opcode} !== '0) begin errors++; $display("FAIL reset_rsp got %h exp 0", rsp_result); end
    checks++; if ({stat_issued, stat_zero} !== 32'h0) begin errors++; $display("FAIL reset_stats got %h exp 0", {stat_issued, stat_zero}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    @(posedge clk); #1;
    q.delete();
    send_cmd(OP_ADD, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    wait_rsp(1, 20);
    checks++; if (q[0].result !== 8'h0A) begin errors++; $display("FAIL add_result got %h exp 0a", q[0].result); end
    checks++; if (q[0].zero !== 1'b0 || q[0].op !== 3'b000) begin errors++; $display("FAIL add_zero_op got %b/%b exp 0/000", q[0].zero, q[0].op); end
    checks++; if (q[0].cyc - last_hs !== 3) begin errors++; $display("FAIL add_latency got %0d exp 3", q[0].cyc - last_hs); end
    checks++; if ({alu_a, alu_b, alu_c, alu_d} !== 32'h01020304) begin errors++; $display("FAIL add_alu_held got %h exp 01020304", {alu_a, alu_b, alu_c, alu_d}); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL add_idle got busy=%b valid=%b exp 0/0", busy, rsp_valid); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    checks++; if (stat_issued !== 16'h0) begin errors++; $display("FAIL clr_issued got %h exp 0", stat_issued); end
    @(posedge clk); #1;
    q.delete();
    send_cmd(OP_SUB, 8'd5, 8'd7, 8'd0, 8'd0, 1'b0);
    send_cmd(OP_SEL_SUM, 8'h80, 8'h01, 8'h80, 8'h01, 1'b1);
    wait_rsp(2, 30);
    checks++; if (q[0].result !== 8'hFE || q[0].zero !== 1'b0 || q[0].op !== OP_SUB) begin errors++; $display("FAIL b2b_first got %h/%b/%0d exp fe/0/1", q[0].result, q[0].zero, q[0].op); end
    checks++; if (q[1].result !== 8'h00 || q[1].zero !== 1'b1 || q[1].op !== OP_SEL_SUM) begin errors++; $display("FAIL b2b_second got %h/%b/%0d exp 00/1/6", q[1].result, q[1].zero, q[1].op); end
    checks++; if (q[1].cyc - q[0].cyc !== 2) begin errors++; $display("FAIL b2b_spacing got %0d exp 2", q[1].cyc - q[0].cyc); end
    checks++; if (stat_zero !== 16'd1 || stat_issued !== 16'd2) begin errors++; $display("FAIL b2b_stats got %0d/%0d exp 1/2", stat_zero, stat_issued); end
  endtask

  task automatic test_stall();
    bit ok = 0;
    int hs6 = 0;
    @(posedge clk); #1;
    q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(OP_ADD, 8'(16 + i), 8'd0, 8'd0, 8'd0, 1'b0);
    cmd_opcode = OP_ADD; cmd_a = 8'h15; cmd_b = '0; cmd_c = '0; cmd_d = '0; cmd_sel = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 8'h10 || rsp_zero !== 1'b0 || rsp_opcode !== OP_ADD) begin
        errors++; $display("FAIL stall_hold got ready=%b valid=%b res=%h exp 0/1/10", cmd_ready, rsp_valid, rsp_result);
      end
    end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL stall_no_rsp got %0d exp 0", q.size()); end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; hs6 = cyc; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (!ok || hs6 <= q[0].cyc) begin errors++; $display("FAIL stall_sixth_accept got ok=%0d cyc=%0d exp after %0d", ok, hs6, q[0].cyc); end
    wait_rsp(6, 40);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (q[i].result !== 8'(16 + i) || q[i].zero !== 1'b0) begin errors++; $display("FAIL stall_order[%0d] got %h exp %h", i, q[i].result, 8'(16 + i)); end
    end
  endtask

  task automatic test_fifo_laps();
    int pushed = 3;
    @(posedge clk); #1;
    q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_cmd(OP_ADD, 8'(32 + i), 8'(i), 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 200 && pushed < 14; k++) begin
      if (rsp_valid) begin
        checks++;
        if (dut.count !== 3'd2 || cmd_ready !== 1'b1) begin errors++; $display("FAIL laps_occupancy got %0d ready=%b exp 2/1", dut.count, cmd_ready); end
        cmd_opcode = OP_ADD; cmd_a = 8'(32 + pushed); cmd_b = 8'(pushed); cmd_c = '0; cmd_d = '0;
        cmd_valid = 1'b1;
        pushed++;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    checks++; if (pushed !== 14) begin errors++; $display("FAIL laps_pushed got %0d exp 14", pushed); end
    wait_rsp(14, 100);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (q[i].result !== 8'(32 + 2 * i)) begin errors++; $display("FAIL laps_order[%0d] got %h exp %h", i, q[i].result, 8'(32 + 2 * i)); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    q.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(OP_ADD, 8'(64 + i), 8'd0, 8'd0, 8'd0, 1'b0);
    cmd_opcode = OP_ADD; cmd_a = 8'h44; cmd_b = '0; cmd_c = '0; cmd_d = '0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (alu_a !== 8'h41 || dut.count !== 3'd3) begin errors++; $display("FAIL rstmid_setup got a=%h occ=%0d exp 41/3", alu_a, dut.count); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctrl got valid=%b busy=%b ready=%b exp 0/0/1", rsp_valid, busy, cmd_ready); end
    checks++; if ({alu_a, alu_b, alu_c, alu_d, alu_opcode, alu_sel} !== '0) begin errors++; $display("FAIL rstmid_alu got %h exp 0", alu_a); end
    checks++; if ({stat_issued, stat_zero} !== 32'h0) begin errors++; $display("FAIL rstmid_stats got %h exp 0", {stat_issued, stat_zero}); end
    repeat (12) @(negedge clk);
    checks++; if (q.size() !== 1 || q[0].result !== 8'h40) begin errors++; $display("FAIL rstmid_no_stale got n=%0d res=%h exp 1/40", q.size(), q[0].result); end
  endtask

  task automatic test_stat_saturation();
    @(posedge clk); #1;
    force dut.stat_issued = 16'hFFFE;
    @(posedge clk); #1;
    release dut.stat_issued;
    @(negedge clk);
    checks++; if (stat_issued !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h exp fffe", stat_issued); end
    @(posedge clk); #1;
    q.delete();
    for (int i = 0; i < 3; i++) send_cmd(OP_ADD, 8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    wait_rsp(3, 30);
    checks++; if (stat_issued !== 16'hFFFF) begin errors++; $display("FAIL sat_issued got %h exp ffff", stat_issued); end
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    checks++; if (stat_issued !== 16'h0 || stat_zero !== 16'h0) begin errors++; $display("FAIL sat_clear got %h/%h exp 0/0", stat_issued, stat_zero); end
    @(posedge clk); #1;
    q.delete();
    send_cmd(OP_AND, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b0);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    checks++; if (stat_issued !== 16'h0) begin errors++; $display("FAIL clr_vs_inc got %h exp 0", stat_issued); end
    wait_rsp(1, 20);
    checks++; if (q[0].result !== 8'h00 || q[0].zero !== 1'b1 || q[0].op !== OP_AND) begin errors++; $display("FAIL and_zero got %h/%b exp 00/1", q[0].result, q[0].zero); end
    @(negedge clk);
    checks++; if (stat_zero !== 16'd1 || stat_issued !== 16'd0) begin errors++; $display("FAIL post_clr_stats got %0d/%0d exp 1/0", stat_zero, stat_issued); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_fifo_laps();
    test_reset_mid();
    test_stat_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
